// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef enum logic {
        ARB  = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester handshakes plus single-port memory command/response bundle.
interface mem_arb_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              req0_valid, req1_valid;
    logic              req0_we,    req1_we;
    logic [ADDR_W-1:0] req0_addr,  req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
               req0_wdata, req1_wdata, mem_rdata,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters and memory side
    modport master (
        output req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
               req0_wdata, req1_wdata, mem_rdata,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin choice: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_gnt,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (valid0 && valid1) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end else if (valid0) begin
            gnt = 2'b01;
        end else if (valid1) begin
            gnt = 2'b10;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port memory between a CPU port and a loader port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    mem_arb_if.slave   bus
);
    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              rsp_id_q, rsp_id_d;
    logic [1:0]        gnt;
    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_arb2 u_rr (
        .valid0   (bus.req0_valid),
        .valid1   (bus.req1_valid),
        .last_gnt (last_gnt_q),
        .gnt      (gnt)
    );

    // Winner's request fields, passed straight through to memory
    assign win       = gnt[1];
    assign win_we    = win ? bus.req1_we    : bus.req0_we;
    assign win_addr  = win ? bus.req1_addr  : bus.req0_addr;
    assign win_wdata = win ? bus.req1_wdata : bus.req0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            last_gnt_q <= REQ_LDR;
            rsp_id_q   <= REQ_CPU;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    // Outputs are forced low while rst is held, even though the FSM already sits in ARB
    always_comb begin
        state_d        = state_q;
        last_gnt_d     = last_gnt_q;
        rsp_id_d       = rsp_id_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp0_rdata = '0;
        bus.rsp1_rdata = '0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        if (!rst) begin
            case (state_q)
                ARB: begin
                    if (gnt != 2'b00) begin
                        bus.req0_ready = gnt[0];
                        bus.req1_ready = gnt[1];
                        bus.mem_en     = 1'b1;
                        bus.mem_we     = win_we;
                        bus.mem_addr   = win_addr;
                        bus.mem_wdata  = win_wdata;
                        last_gnt_d     = win;
                        if (!win_we) begin
                            state_d  = RESP;
                            rsp_id_d = win;
                        end
                    end
                end
                RESP: begin
                    state_d = ARB;
                    if (rsp_id_q == REQ_LDR) begin
                        bus.rsp1_valid = 1'b1;
                        bus.rsp1_rdata = bus.mem_rdata;
                    end else begin
                        bus.rsp0_valid = 1'b1;
                        bus.rsp0_rdata = bus.mem_rdata;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic       v0, we0;
        logic [4:0] a0;
        logic [7:0] d0;
        logic       v1, we1;
        logic [4:0] a1;
        logic [7:0] d1;
    } vin_t;

    typedef struct packed {
        logic       rdy0, rdy1, en, we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic       rv0;
        logic [7:0] rd0;
        logic       rv1;
        logic [7:0] rd1;
    } vout_t;

    typedef struct {
        vin_t  i;
        vout_t o;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] mem [32];
    vec_t vecs [21];

    mem_arb_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the command
    always_ff @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) mem[k] <= 8'(8'h80 + k);
            mem[5] <= 8'h3C;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    function automatic vin_t mk_in(input logic v0, input logic we0, input logic [4:0] a0,
                                   input logic [7:0] d0, input logic v1, input logic we1,
                                   input logic [4:0] a1, input logic [7:0] d1);
        return '{v0, we0, a0, d0, v1, we1, a1, d1};
    endfunction

    function automatic vout_t mk_out(input logic r0, input logic r1, input logic en,
                                     input logic we, input logic [4:0] addr,
                                     input logic [7:0] wd, input logic rv0, input logic [7:0] rd0,
                                     input logic rv1, input logic [7:0] rd1);
        return '{r0, r1, en, we, addr, wd, rv0, rd0, rv1, rd1};
    endfunction

    function automatic vout_t sample();
        return '{bus.req0_ready, bus.req1_ready, bus.mem_en, bus.mem_we, bus.mem_addr,
                 bus.mem_wdata, bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid, bus.rsp1_rdata};
    endfunction

    task automatic drive(input vin_t x);
        bus.req0_valid = x.v0;  bus.req0_we = x.we0;  bus.req0_addr = x.a0;  bus.req0_wdata = x.d0;
        bus.req1_valid = x.v1;  bus.req1_we = x.we1;  bus.req1_addr = x.a1;  bus.req1_wdata = x.d1;
    endtask

    task automatic check(input string name, input vout_t exp);
        vout_t got;
        got = sample();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive on the falling edge, compare 2 time units later, well before the rising edge
    task automatic step(input vin_t x, input vout_t e, input string name);
        @(negedge clk);
        drive(x);
        #2;
        check(name, e);
    endtask

    initial begin
        vin_t  idle;
        vout_t zero;
        idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0);
        zero = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Contention straight after reset: grants 0,1,0,1 each followed by a response cycle
        vecs[0]  = '{mk_in(1,0,5,0, 1,0,7,0), mk_out(1,0,1,0,5,0, 0,0,       0,0)};
        vecs[1]  = '{mk_in(1,0,1,0, 1,0,7,0), mk_out(0,0,0,0,0,0, 1,8'h3C,   0,0)};
        vecs[2]  = '{mk_in(1,0,1,0, 1,0,7,0), mk_out(0,1,1,0,7,0, 0,0,       0,0)};
        vecs[3]  = '{mk_in(1,0,1,0, 1,0,9,0), mk_out(0,0,0,0,0,0, 0,0,       1,8'h87)};
        vecs[4]  = '{mk_in(1,0,1,0, 1,0,9,0), mk_out(1,0,1,0,1,0, 0,0,       0,0)};
        vecs[5]  = '{mk_in(0,0,0,0, 1,0,9,0), mk_out(0,0,0,0,0,0, 1,8'h81,   0,0)};
        vecs[6]  = '{mk_in(0,0,0,0, 1,0,9,0), mk_out(0,1,1,0,9,0, 0,0,       0,0)};
        vecs[7]  = '{idle,                    mk_out(0,0,0,0,0,0, 0,0,       1,8'h89)};
        // Loader write, then CPU reads it back
        vecs[8]  = '{mk_in(0,0,0,0, 1,1,2,8'hA5), mk_out(0,1,1,1,2,8'hA5, 0,0, 0,0)};
        vecs[9]  = '{mk_in(1,0,2,0, 0,0,0,0), mk_out(1,0,1,0,2,0, 0,0,       0,0)};
        vecs[10] = '{idle,                    mk_out(0,0,0,0,0,0, 1,8'hA5,   0,0)};
        // Back-to-back CPU writes on consecutive cycles
        for (int k = 0; k < 4; k++)
            vecs[11+k] = '{mk_in(1,1,5'(k),8'(8'h50+k), 0,0,0,0),
                           mk_out(1,0,1,1,5'(k),8'(8'h50+k), 0,0, 0,0)};
        vecs[15] = '{mk_in(0,0,0,0, 1,0,3,0), mk_out(0,1,1,0,3,0, 0,0,       0,0)};
        vecs[16] = '{idle,                    mk_out(0,0,0,0,0,0, 0,0,       1,8'h53)};
        vecs[17] = '{idle,                    zero};
        // Loader request withdrawn during the CPU response cycle
        vecs[18] = '{mk_in(1,0,0,0, 0,0,0,0), mk_out(1,0,1,0,0,0, 0,0,       0,0)};
        vecs[19] = '{mk_in(0,0,0,0, 1,0,4,0), mk_out(0,0,0,0,0,0, 1,8'h50,   0,0)};
        vecs[20] = '{idle,                    zero};

        drive(mk_in(1,1,5'h1F,8'hFF, 1,0,5'h1E,8'hEE));
        #2;
        check("reset_outputs", zero);
        @(negedge clk);
        preload = 1'b0;
        drive(idle);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 21; k++) step(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));

        // Reset in the RESP cycle of a loader read drops the response
        step(mk_in(0,0,0,0, 1,0,7,0), mk_out(0,1,1,0,7,0, 0,0, 0,0), "ldr_read_accept");
        @(negedge clk);
        drive(mk_in(1,0,1,0, 1,0,2,0));
        rst = 1'b1;
        #2;
        check("rst_in_resp_outputs", zero);
        @(negedge clk);
        drive(idle);
        rst = 1'b0;
        #2;
        check("no_rsp_after_rst", zero);
        step(idle, zero, "still_no_rsp");
        step(mk_in(1,0,3,0, 1,0,4,0), mk_out(1,0,1,0,3,0, 0,0, 0,0), "tie_after_rst");
        step(idle, mk_out(0,0,0,0,0,0, 1,8'h53, 0,0), "tie_after_rst_rsp");

        // last_gnt returns to the loader on reset even after a CPU grant
        step(mk_in(1,1,10,8'h77, 0,0,0,0), mk_out(1,0,1,1,10,8'h77, 0,0, 0,0), "cpu_write_pre_rst");
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(mk_in(1,0,10,0, 1,0,11,0), mk_out(1,0,1,0,10,0, 0,0, 0,0), "tie_after_rst2");
        step(idle, mk_out(0,0,0,0,0,0, 1,8'h77, 0,0), "tie_after_rst2_rsp");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
